// File: rtl/bitrev_reorder_buf.sv
// Ping-pong reorder buffer: accepts FFT output in bit-reversed order, emits natural order.
// Optional macro BITREV_TLAST_CHECK_EN enables the sticky err_tlast framing check.
module bitrev_reorder_buf #(
    parameter int FFT_LEN = 8,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    output logic             err_tlast
);

    localparam int AW = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(FFT_LEN - 1);

    // Bank select is the MSB of the address, so both banks share one array.
    logic [WIDTH-1:0] mem [2*FFT_LEN];

    logic            wb_reg;
    logic            rb_reg;
    logic [AW-1:0]   wr_cnt_reg;
    logic [AW-1:0]   rd_cnt_reg;
    logic [1:0]      full_reg;
    logic [1:0]      full_next;
    logic [AW-1:0]   wr_addr_rev;

    logic wr_fire;
    logic rd_fire;
    logic wr_last;
    logic rd_last;

    generate
        for (genvar gi = 0; gi < AW; gi++) begin : g_bitrev
            assign wr_addr_rev[gi] = wr_cnt_reg[AW-1-gi];
        end
    endgenerate

    assign s_axis_tready = !full_reg[wb_reg];
    assign m_axis_tvalid = full_reg[rb_reg];
    assign m_axis_tdata  = mem[{rb_reg, rd_cnt_reg}];
    assign rd_last       = (rd_cnt_reg == LAST_IDX);
    assign wr_last       = (wr_cnt_reg == LAST_IDX);
    assign m_axis_tlast  = full_reg[rb_reg] && rd_last;

    assign wr_fire = s_axis_tvalid && s_axis_tready;
    assign rd_fire = m_axis_tvalid && m_axis_tready;

    // A write can only target an empty bank and a read only a full one, so a
    // simultaneous set and clear always land on different banks.
    always_comb begin
        full_next = full_reg;
        if (wr_fire && wr_last) begin
            full_next[wb_reg] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            full_next[rb_reg] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wb_reg, wr_addr_rev}] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_reg     <= 1'b0;
            rb_reg     <= 1'b0;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            full_reg   <= 2'b00;
        end else begin
            full_reg <= full_next;
            if (wr_fire) begin
                wr_cnt_reg <= wr_last ? '0 : wr_cnt_reg + 1'b1;
                if (wr_last) begin
                    wb_reg <= !wb_reg;
                end
            end
            if (rd_fire) begin
                rd_cnt_reg <= rd_last ? '0 : rd_cnt_reg + 1'b1;
                if (rd_last) begin
                    rb_reg <= !rb_reg;
                end
            end
        end
    end

`ifdef BITREV_TLAST_CHECK_EN
    logic err_tlast_reg;

    // Framing is driven purely by wr_cnt; tlast is only compared, never obeyed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_tlast_reg <= 1'b0;
        end else if (wr_fire && (s_axis_tlast != wr_last)) begin
            err_tlast_reg <= 1'b1;
        end
    end

    assign err_tlast = err_tlast_reg;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Randomized bench for bitrev_reorder_buf with a frame-level reference model.
// Honours BITREV_TLAST_CHECK_EN when deciding the expected err_tlast behaviour.
module tb_bitrev_reorder_buf;

    localparam int N    = 8;
    localparam int LOGN = 3;
    localparam int W    = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic         err_tlast;

    bitrev_reorder_buf #(.FFT_LEN(N), .WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_tlast     (err_tlast)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rdy_prob = 100;
    int wr_total = 0;

    // Reference model: frames are collected in arrival order, then released
    // in natural order (output k is the sample written at position bitrev(k)).
    logic [W-1:0] cur[N];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    bit           tl_log[$];
    int           widx = 0;
    int           rpos = 0;
    int           nfull = 0;
    bit           err_exp = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int brev(input int i);
        int r = 0;
        for (int b = 0; b < LOGN; b++) begin
            if ((i >> b) & 1) r |= 1 << (LOGN - 1 - b);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = (rdy_prob >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_prob);
        end
    end

    // Compare process: checks outputs at negedge, advances the model at posedge.
    initial begin
        bit           wfire;
        bit           rfire;
        bit           wtl;
        logic [W-1:0] wdat;
        forever begin
            @(negedge clk);
            wfire = 1'b0;
            rfire = 1'b0;
            if (rst) begin
                exp_q.delete();
                widx = 0; rpos = 0; nfull = 0; err_exp = 1'b0; prev_stall = 1'b0;
                chk("rst_m_valid", {31'b0, m_axis_tvalid}, 0);
                chk("rst_s_ready", {31'b0, s_axis_tready}, 1);
                chk("rst_m_last", {31'b0, m_axis_tlast}, 0);
                chk("rst_err", {31'b0, err_tlast}, 0);
            end else begin
                chk("m_valid", {31'b0, m_axis_tvalid}, {31'b0, nfull > 0});
                chk("s_ready", {31'b0, s_axis_tready}, {31'b0, nfull < 2});
                chk("m_last", {31'b0, m_axis_tlast}, {31'b0, (nfull > 0) && (rpos == N - 1)});
                chk("err_tlast", {31'b0, err_tlast}, {31'b0, err_exp});
                if (m_axis_tvalid && exp_q.size() > 0)
                    chk("m_data", {16'b0, m_axis_tdata}, {16'b0, exp_q[0]});
                if (prev_stall) begin
                    chk("stall_valid", {31'b0, m_axis_tvalid}, 1);
                    chk("stall_data", {16'b0, m_axis_tdata}, {16'b0, prev_data});
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                wfire = s_axis_tvalid && s_axis_tready;
                rfire = m_axis_tvalid && m_axis_tready;
                wdat  = s_axis_tdata;
                wtl   = s_axis_tlast;
                if (rfire) begin
                    out_log.push_back(m_axis_tdata);
                    tl_log.push_back(m_axis_tlast);
                end
            end
            @(posedge clk);
            if (wfire) begin
                cur[widx] = wdat;
`ifdef BITREV_TLAST_CHECK_EN
                if (wtl != (widx == N - 1)) err_exp = 1'b1;
`else
                if (wtl) err_exp = err_exp;
`endif
                widx++;
                if (widx == N) begin
                    for (int k = 0; k < N; k++) exp_q.push_back(cur[brev(k)]);
                    nfull++;
                    widx = 0;
                end
            end
            if (rfire) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                rpos++;
                if (rpos == N) begin
                    rpos = 0;
                    nfull--;
                end
            end
        end
    end

    task automatic send_frames(input int nfr, input int vprob, input bit brdata, input int bad_idx);
        logic [W-1:0] d;
        int  guard;
        bit  acc;
        for (int f = 0; f < nfr; f++) begin
            for (int idx = 0; idx < N; idx++) begin
                d = brdata ? W'(brev(idx)) : W'($urandom);
                guard = 0;
                acc = 1'b0;
                while (!acc) begin
                    s_axis_tvalid = ($urandom_range(0, 99) < vprob);
                    s_axis_tdata  = d;
                    s_axis_tlast  = (idx == N - 1) || (idx == bad_idx);
                    @(negedge clk);
                    acc = s_axis_tvalid && s_axis_tready;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (!acc && guard > 3000) begin
                        chk("write_timeout", 0, 1);
                        s_axis_tvalid = 1'b0;
                        return;
                    end
                end
                wr_total++;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((m_axis_tvalid || nfull != 0) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_idle", {31'b0, m_axis_tvalid}, 0);
    endtask

    task automatic check_natural_log(input string tag);
        chk({tag, "_count"}, out_log.size(), N);
        for (int k = 0; k < N && k < out_log.size(); k++) begin
            chk({tag, "_data"}, {16'b0, out_log[k]}, k);
            chk({tag, "_last"}, {31'b0, tl_log[k]}, {31'b0, k == N - 1});
        end
    endtask

    initial begin
        int start;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", {31'b0, m_axis_tvalid}, 0);
        chk("reset_ready", {31'b0, s_axis_tready}, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame of bitrev(i): output must be 0..7, first valid one cycle later
        out_log.delete(); tl_log.delete();
        chk("pre_frame_valid", {31'b0, m_axis_tvalid}, 0);
        send_frames(1, 100, 1'b1, -1);
        @(negedge clk);
        chk("latency_valid", {31'b0, m_axis_tvalid}, 1);
        chk("first_data", {16'b0, m_axis_tdata}, 0);
        @(posedge clk);
        #1;
        wait_idle();
        check_natural_log("frame0");

        // Three back-to-back frames with both sides always ready: no stalls
        start = cyc;
        send_frames(3, 100, 1'b0, -1);
        chk("b2b_cycles", cyc - start, 3 * N);
        wait_idle();

        // Downstream blocked: exactly two frames fit
        rdy_prob = 0;
        @(posedge clk);
        #1;
        wr_total = 0;
        fork
            send_frames(3, 100, 1'b0, -1);
            begin
                repeat (40) @(negedge clk);
                chk("stall_writes", wr_total, 2 * N);
                chk("stall_s_ready", {31'b0, s_axis_tready}, 0);
                chk("stall_m_valid", {31'b0, m_axis_tvalid}, 1);
                rdy_prob = 100;
            end
        join
        wait_idle();

        // Random valid/ready over 20 frames
        rdy_prob = 50;
        send_frames(20, 60, 1'b0, -1);
        rdy_prob = 100;
        wait_idle();

        // Reset mid-frame with a full bank pending
        rdy_prob = 0;
        send_frames(1, 100, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'($urandom);
            s_axis_tlast  = 1'b0;
            @(posedge clk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        chk("pre_rst_valid", {31'b0, m_axis_tvalid}, 1);
        rst = 1'b1;
        #1;
        chk("rst_now_valid", {31'b0, m_axis_tvalid}, 0);
        chk("rst_now_ready", {31'b0, s_axis_tready}, 1);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_prob = 100;
        out_log.delete(); tl_log.delete();
        send_frames(1, 100, 1'b1, -1);
        wait_idle();
        check_natural_log("post_rst");

        // Misplaced tlast on write 3: flag (if enabled) is sticky, data unaffected
        out_log.delete(); tl_log.delete();
        send_frames(1, 100, 1'b1, 3);
        wait_idle();
        check_natural_log("bad_tlast");
        send_frames(1, 100, 1'b0, -1);
        wait_idle();
`ifdef BITREV_TLAST_CHECK_EN
        chk("err_sticky", {31'b0, err_tlast}, 1);
`else
        chk("err_tied", {31'b0, err_tlast}, 0);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bitrev_reorder_buf.md
BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

Interface
REQ-001 Parameter FFT_LEN, default 8, frame length; SHALL be a power of two, at least 2.
REQ-002 Parameter WIDTH, default 16, sample data width in bits.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_axis_tdata  input  WIDTH  sample from the FFT, arriving in bit-reversed index order.
REQ-006 s_axis_tvalid  input  1  upstream sample valid.
REQ-007 s_axis_tlast  input  1  upstream end-of-frame marker.
REQ-008 s_axis_tready  output  1  block can accept a sample.
REQ-009 m_axis_tdata  output  WIDTH  sample in natural index order.
REQ-010 m_axis_tvalid  output  1  output sample valid.
REQ-011 m_axis_tlast  output  1  SHALL be high on output index FFT_LEN-1.
REQ-012 m_axis_tready  input  1  downstream accepts the sample.
REQ-013 err_tlast  output  1  sticky framing error flag.

Function
REQ-014 Storage SHALL be two banks (ping-pong) of FFT_LEN x WIDTH.
- Each bank has a full flag.
- Write pointer: wb (1 bit). Read pointer: rb (1 bit).
REQ-015 Write acceptance:
- A write SHALL occur when s_axis_tvalid && s_axis_tready.
- Data SHALL be stored at bank wb, address bitrev(wr_cnt).
- wr_cnt is log2(FFT_LEN) bits and SHALL increment on each write.
REQ-016 s_axis_tready SHALL equal !full[wb].
REQ-017 Write frame end: on the write with wr_cnt == FFT_LEN-1:
- full[wb] SHALL be set.
- wb SHALL toggle.
- wr_cnt SHALL wrap to 0.
REQ-018 Read output:
- m_axis_tvalid SHALL equal full[rb].
- m_axis_tdata SHALL be bank rb, address rd_cnt (combinational read, natural order).
REQ-019 On each m_axis_tvalid && m_axis_tready, rd_cnt SHALL increment.
REQ-020 Read frame end: on the transfer with rd_cnt == FFT_LEN-1:
- full[rb] SHALL clear.
- rb SHALL toggle.
- rd_cnt SHALL wrap to 0.
REQ-021 Latency: m_axis_tvalid SHALL rise the cycle after the last input sample of a frame is written, provided the read bank was empty.
REQ-022 Simultaneous write-frame-end and read-frame-end in one cycle SHALL both take effect: one bank sets, the other clears.
REQ-023 Both banks full: s_axis_tready SHALL be 0 until the reader releases a bank.
- Sustained throughput SHALL be one sample per cycle when both sides are always ready.
REQ-024 m_axis_tvalid, once high, SHALL stay high and m_axis_tdata stable until the transfer completes.

Reset
REQ-025 On rst high (asynchronous), the following SHALL be 0: wb, rb, wr_cnt, rd_cnt, full[1:0], err_tlast.
- Outputs SHALL therefore be m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1.
REQ-026 Bank RAM contents SHALL NOT be reset.
REQ-027 Reset mid-frame SHALL discard all partial and full frames.
- The first write after reset SHALL be index 0 of a new frame.

Configuration
REQ-028 Macro BITREV_TLAST_CHECK_EN, when defined:
- err_tlast SHALL be set when an accepted s_axis_tlast disagrees with (wr_cnt == FFT_LEN-1).
- err_tlast SHALL stay set until reset.
- Data flow SHALL be unaffected; framing SHALL follow wr_cnt only.
REQ-029 Macro not defined: err_tlast SHALL be tied 0 and s_axis_tlast ignored.

Verification (FFT_LEN=8, WIDTH=16)
REQ-030 One frame in, tdata = bitrev(i) for write i (sequence 0,4,2,6,1,5,3,7), m_axis_tready=1:
- Output SHALL be 0..7.
- m_axis_tlast SHALL be high only on value 7.
- First m_axis_tvalid SHALL occur 1 cycle after the 8th write.
REQ-031 Three back-to-back frames, both sides always ready: no s_axis_tready deassertion; outputs in natural order per frame.
REQ-032 m_axis_tready=0, three frames offered:
- s_axis_tready SHALL fall after the 16th write.
- After m_axis_tready=1, frame 1 is output first, then frame 2; the 3rd frame is then accepted.
REQ-033 Random valid/ready toggling over 20 frames: scoreboard SHALL match natural order and m_axis_tdata SHALL be stable while stalled.
REQ-034 rst asserted after 5 writes:
- m_axis_tvalid SHALL be 0 and s_axis_tready SHALL be 1 immediately.
- The next 8 writes SHALL form a clean frame.
REQ-035 With BITREV_TLAST_CHECK_EN: s_axis_tlast on write 3 SHALL set err_tlast the next cycle, sticky, while the data output is unchanged.
